// File: rtl/rv32i_system_unit_if.sv
// Command/result handshake bundle between decode, the SYSTEM unit and writeback/trap logic.
// The master side offers SYSTEM instructions and consumes results; the slave side is the unit.
interface rv32i_system_unit_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_funct3;
  logic [11:0] cmd_funct12;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rd;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  result_rd;
  logic [31:0] result_data;
  logic        result_exception;
  logic [3:0]  result_cause;

  modport master (
    output cmd_valid, cmd_funct3, cmd_funct12, cmd_rs1, cmd_rd, result_ready,
    input  cmd_ready, result_valid, result_rd, result_data, result_exception, result_cause
  );

  modport slave (
    input  cmd_valid, cmd_funct3, cmd_funct12, cmd_rs1, cmd_rd, result_ready,
    output cmd_ready, result_valid, result_rd, result_data, result_exception, result_cause
  );
endinterface

// File: rtl/rv32i_system_unit.sv
// RV32I SYSTEM-opcode unit: owns the cycle/time/instret counters, services read-only counter
// CSR reads and turns ECALL/EBREAK/illegal SYSTEM encodings into trap responses.
module rv32i_system_unit #(
  parameter int unsigned TIME_DIVIDER  = 1,
  parameter logic [63:0] CYCLE_RESET   = 64'h0,
  parameter logic [63:0] INSTRET_RESET = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 retire,
  rv32i_system_unit_if.slave   bus
);

  localparam int unsigned PW = (TIME_DIVIDER > 1) ? $clog2(TIME_DIVIDER) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(TIME_DIVIDER - 1);

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  typedef enum logic {IDLE, RESP} state_t;

  logic [63:0]   cycle_q, cycle_d;
  logic [63:0]   time_q, time_d;
  logic [63:0]   instret_q, instret_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic          time_tick;

  state_t        state_q;
  logic          cmd_ready_q;
  logic          result_valid_q;
  logic [4:0]    result_rd_q;
  logic [31:0]   result_data_q;
  logic          result_exception_q;
  logic [3:0]    result_cause_q;

  logic [31:0]   csr_val;
  logic          csr_hit;
  logic          dec_exception;
  logic [3:0]    dec_cause;
  logic [31:0]   dec_data;

  // Counters free-run in every FSM state; 64-bit adds wrap naturally.
  assign time_tick  = (prescale_q == PRESCALE_LAST);
  assign prescale_d = time_tick ? '0 : prescale_q + 1'b1;
  assign cycle_d    = cycle_q + 64'd1;
  assign time_d     = time_tick ? time_q + 64'd1 : time_q;
  assign instret_d  = retire ? instret_q + 64'd1 : instret_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q    <= CYCLE_RESET;
      time_q     <= 64'h0;
      instret_q  <= INSTRET_RESET;
      prescale_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      time_q     <= time_d;
      instret_q  <= instret_d;
      prescale_q <= prescale_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    csr_hit = 1'b1;
    csr_val = '0;
    case (bus.cmd_funct12)
      12'hC00: csr_val = cycle_q[31:0];
      12'hC80: csr_val = cycle_q[63:32];
      12'hC01: csr_val = time_q[31:0];
      12'hC81: csr_val = time_q[63:32];
      12'hC02: csr_val = instret_q[31:0];
      12'hC82: csr_val = instret_q[63:32];
      default: csr_hit = 1'b0;
    endcase

    dec_exception = 1'b1;
    dec_cause     = CAUSE_ILLEGAL;
    dec_data      = '0;
    case (bus.cmd_funct3)
      3'd0: begin
        if (bus.cmd_rs1 == 5'd0 && bus.cmd_funct12 == 12'h000)      dec_cause = CAUSE_ECALL;
        else if (bus.cmd_rs1 == 5'd0 && bus.cmd_funct12 == 12'h001) dec_cause = CAUSE_BREAK;
      end
      // Set/clear forms with a zero source are pure reads; anything else would write a read-only CSR.
      3'd2, 3'd3, 3'd6, 3'd7: begin
        if (bus.cmd_rs1 == 5'd0 && csr_hit) begin
          dec_exception = 1'b0;
          dec_cause     = 4'd0;
          dec_data      = csr_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      cmd_ready_q        <= 1'b1;
      result_valid_q     <= 1'b0;
      result_rd_q        <= '0;
      result_data_q      <= '0;
      result_exception_q <= 1'b0;
      result_cause_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            state_q            <= RESP;
            cmd_ready_q        <= 1'b0;
            result_valid_q     <= 1'b1;
            result_rd_q        <= bus.cmd_rd;
            result_data_q      <= dec_data;
            result_exception_q <= dec_exception;
            result_cause_q     <= dec_cause;
          end
        end
        RESP: begin
          if (bus.result_ready) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b1;
            result_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.result_valid     = result_valid_q;
  assign bus.result_rd        = result_rd_q;
  assign bus.result_data      = result_data_q;
  assign bus.result_exception = result_exception_q;
  assign bus.result_cause     = result_cause_q;

endmodule

// File: tb/tb_rv32i_system_unit.sv
// Directed bench for rv32i_system_unit: decode table, counter snapshots, rollover, stall and reset.
// Expected counter values come from edge/retire counts kept by the bench itself.
module tb_rv32i_system_unit;

  localparam int unsigned TIME_DIV  = 4;
  localparam logic [63:0] CYC_RST   = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam logic [63:0] RET_RST   = 64'h0;

  typedef enum logic [2:0] {S_NONE, S_CYC_LO, S_CYC_HI, S_TIM_LO, S_TIM_HI, S_RET_LO, S_RET_HI} sel_e;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [11:0] f12;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        exc;
    logic [3:0]  cause;
    sel_e        sel;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic retire = 1'b0;

  rv32i_system_unit_if bus ();

  rv32i_system_unit #(
    .TIME_DIVIDER (TIME_DIV),
    .CYCLE_RESET  (CYC_RST),
    .INSTRET_RESET(RET_RST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .retire(retire),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] edges;
  logic [63:0] ret_cnt;
  logic [63:0] snap_edges;
  logic [63:0] snap_ret;

  // Reference counts: clock edges and retire pulses seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges   <= '0;
      ret_cnt <= '0;
    end else begin
      edges   <= edges + 64'd1;
      if (retire) ret_cnt <= ret_cnt + 64'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_data(input sel_e sel, input logic [63:0] e, input logic [63:0] r);
    logic [63:0] cyc;
    logic [63:0] tim;
    logic [63:0] ret;
    cyc = CYC_RST + e;
    tim = e / TIME_DIV;
    ret = RET_RST + r;
    case (sel)
      S_CYC_LO: return cyc[31:0];
      S_CYC_HI: return cyc[63:32];
      S_TIM_LO: return tim[31:0];
      S_TIM_HI: return tim[63:32];
      S_RET_LO: return ret[31:0];
      S_RET_HI: return ret[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [2:0] f3, input logic [11:0] f12, input logic [4:0] rs1, input logic [4:0] rd);
    bus.cmd_funct3  = f3;
    bus.cmd_funct12 = f12;
    bus.cmd_rs1     = rs1;
    bus.cmd_rd      = rd;
    bus.cmd_valid   = 1'b1;
    snap_edges = edges;
    snap_ret   = ret_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_resp(input string name, input logic [4:0] rd, input logic exc,
                            input logic [3:0] cause, input logic [31:0] data);
    check({name, ".valid"}, 64'(bus.result_valid), 64'd1);
    check({name, ".rd"},    64'(bus.result_rd), 64'(rd));
    check({name, ".exc"},   64'(bus.result_exception), 64'(exc));
    check({name, ".cause"}, 64'(bus.result_cause), 64'(cause));
    check({name, ".data"},  64'(bus.result_data), 64'(data));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"ecall",        3'd0, 12'h000, 5'd0, 5'd1,  1'b1, 4'd11, S_NONE};
    vecs[1]  = '{"ebreak",       3'd0, 12'h001, 5'd0, 5'd2,  1'b1, 4'd3,  S_NONE};
    vecs[2]  = '{"env_002",      3'd0, 12'h002, 5'd0, 5'd3,  1'b1, 4'd2,  S_NONE};
    vecs[3]  = '{"ecall_rs1",    3'd0, 12'h000, 5'd1, 5'd4,  1'b1, 4'd2,  S_NONE};
    vecs[4]  = '{"csrrw_c00",    3'd1, 12'hC00, 5'd0, 5'd5,  1'b1, 4'd2,  S_NONE};
    vecs[5]  = '{"csrrsi_z1",    3'd6, 12'hC00, 5'd1, 5'd6,  1'b1, 4'd2,  S_NONE};
    vecs[6]  = '{"csrrs_300",    3'd2, 12'h300, 5'd0, 5'd7,  1'b1, 4'd2,  S_NONE};
    vecs[7]  = '{"funct3_4",     3'd4, 12'hC00, 5'd0, 5'd8,  1'b1, 4'd2,  S_NONE};
    vecs[8]  = '{"csrrwi_c01",   3'd5, 12'hC01, 5'd0, 5'd9,  1'b1, 4'd2,  S_NONE};
    vecs[9]  = '{"csrrc_c80",    3'd3, 12'hC80, 5'd0, 5'd10, 1'b0, 4'd0,  S_CYC_HI};
    vecs[10] = '{"csrrsi_c81",   3'd6, 12'hC81, 5'd0, 5'd11, 1'b0, 4'd0,  S_TIM_HI};
    vecs[11] = '{"csrrci_c01",   3'd7, 12'hC01, 5'd0, 5'd12, 1'b0, 4'd0,  S_TIM_LO};
    vecs[12] = '{"csrrs_c82",    3'd2, 12'hC82, 5'd0, 5'd13, 1'b0, 4'd0,  S_RET_HI};
    vecs[13] = '{"csrrs_c02_r3", 3'd2, 12'hC02, 5'd3, 5'd14, 1'b1, 4'd2,  S_NONE};

    bus.cmd_valid    = 1'b0;
    bus.cmd_funct3   = '0;
    bus.cmd_funct12  = '0;
    bus.cmd_rs1      = '0;
    bus.cmd_rd       = '0;
    bus.result_ready = 1'b1;

    // Reset state, then a read in the very first idle cycle.
    repeat (3) @(negedge clk);
    check("rst.valid", 64'(bus.result_valid), 64'd0);
    check("rst.rd",    64'(bus.result_rd), 64'd0);
    check("rst.data",  64'(bus.result_data), 64'd0);
    check("rst.exc",   64'(bus.result_exception), 64'd0);
    check("rst.cause", 64'(bus.result_cause), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    issue(3'd2, 12'hC00, 5'd0, 5'd5);
    check_resp("first_c00", 5'd5, 1'b0, 4'd0, 32'hFFFF_FFF0);
    @(negedge clk);
    check("first.idle_valid", 64'(bus.result_valid), 64'd0);

    // Decode table.
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].f3, vecs[i].f12, vecs[i].rs1, vecs[i].rd);
      check_resp(vecs[i].name, vecs[i].rd, vecs[i].exc, vecs[i].cause,
                 model_data(vecs[i].sel, snap_edges, snap_ret));
      @(negedge clk);
    end

    // Cycle counter has crossed 2^64 by now: high half is back to 0, low half counts on.
    issue(3'd2, 12'hC00, 5'd0, 5'd15);
    check_resp("wrap_c00", 5'd15, 1'b0, 4'd0, model_data(S_CYC_LO, snap_edges, snap_ret));
    check("wrap_c00.elapsed", 64'(bus.result_data), snap_edges - 64'd16);
    @(negedge clk);
    issue(3'd2, 12'hC80, 5'd0, 5'd16);
    check_resp("wrap_c80", 5'd16, 1'b0, 4'd0, 32'h0);
    @(negedge clk);

    // Time after 20 idle cycles with divider 4, then a 10-cycle stall.
    do_reset();
    repeat (20) @(negedge clk);
    bus.result_ready = 1'b0;
    issue(3'd2, 12'hC01, 5'd0, 5'd17);
    check_resp("time20", 5'd17, 1'b0, 4'd0, 32'd5);
    bus.cmd_funct3  = 3'd0;
    bus.cmd_funct12 = 12'h000;
    bus.cmd_rs1     = 5'd0;
    bus.cmd_rd      = 5'd1;
    bus.cmd_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall.valid",     64'(bus.result_valid), 64'd1);
      check("stall.cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("stall.rd",        64'(bus.result_rd), 64'd17);
      check("stall.data",      64'(bus.result_data), 64'd5);
      check("stall.exc",       64'(bus.result_exception), 64'd0);
    end
    bus.cmd_valid    = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    check("stall.release_valid", 64'(bus.result_valid), 64'd0);
    check("stall.release_ready", 64'(bus.cmd_ready), 64'd1);
    issue(3'd2, 12'hC01, 5'd0, 5'd18);
    check_resp("time_after_stall", 5'd18, 1'b0, 4'd0, model_data(S_TIM_LO, snap_edges, snap_ret));
    @(negedge clk);

    // Seven retire pulses, the last one in the acceptance cycle.
    do_reset();
    retire = 1'b1;
    repeat (6) @(negedge clk);
    issue(3'd2, 12'hC02, 5'd0, 5'd19);
    retire = 1'b0;
    check_resp("instret6", 5'd19, 1'b0, 4'd0, 32'd6);
    @(negedge clk);
    issue(3'd2, 12'hC02, 5'd0, 5'd20);
    check_resp("instret7", 5'd20, 1'b0, 4'd0, 32'd7);
    @(negedge clk);

    // Reset while a result is stalled in RESP.
    bus.result_ready = 1'b0;
    issue(3'd0, 12'h001, 5'd0, 5'd21);
    check_resp("pre_rst_ebreak", 5'd21, 1'b1, 4'd3, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.valid", 64'(bus.result_valid), 64'd0);
    check("mid_rst.exc",   64'(bus.result_exception), 64'd0);
    check("mid_rst.cause", 64'(bus.result_cause), 64'd0);
    check("mid_rst.rd",    64'(bus.result_rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.result_ready = 1'b1;
    issue(3'd2, 12'hC00, 5'd0, 5'd22);
    check_resp("post_rst_c00", 5'd22, 1'b0, 4'd0, 32'hFFFF_FFF0);
    @(negedge clk);
    issue(3'd2, 12'hC80, 5'd0, 5'd23);
    check_resp("post_rst_c80", 5'd23, 1'b0, 4'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    issue(3'd2, 12'hC02, 5'd0, 5'd24);
    check_resp("post_rst_c02", 5'd24, 1'b0, 4'd0, 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_system_unit.md
Name: rv32i_system_unit

Overview:
Execution unit and controller for RV32I SYSTEM-opcode instructions (opcode 0x73). Owns the 64-bit cycle, time and instret counters. Services the read-only CSR instructions targeting those counters and converts ECALL, EBREAK and illegal SYSTEM encodings into trap responses. Sits beside the ALU after decode, with a valid/ready command input and a valid/ready result output toward writeback/trap logic.

Parameters:
TIME_DIVIDER, 1, clk cycles per time increment (>=1)
CYCLE_RESET, 64'h0, reset value of cycle counter
INSTRET_RESET, 64'h0, reset value of instret counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  SYSTEM instruction offered
cmd_ready  output  1  unit can accept a command
cmd_funct3  input  3  funct3 field (ENV/CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI)
cmd_funct12  input  12  inst[31:20]; CSR address or ENV code
cmd_rs1  input  5  rs1 field / zimm
cmd_rd  input  5  destination register
retire  input  1  one instruction retired this cycle
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
result_rd  output  5  echoed rd
result_data  output  32  CSR read value; 0 on exception
result_exception  output  1  trap required
result_cause  output  4  mcause code: 2 illegal, 3 breakpoint, 11 ecall

Behaviour:
- Reset (async, rst_n low): cycle=CYCLE_RESET; instret=INSTRET_RESET; time=0; prescaler=0; state=IDLE. All result_* outputs 0; cmd_ready=1 once rst_n deasserts. A command or result in flight is discarded.
- Counters:
  - cycle increments every clk.
  - Prescaler counts 0..TIME_DIVIDER-1; time increments on the cycle the prescaler wraps. With TIME_DIVIDER=1, time increments every clk.
  - instret increments when retire=1.
  - All counters are 64-bit and wrap 2^64-1 -> 0.
- FSM states IDLE, RESP:
  - IDLE: cmd_ready=1, result_valid=0. When cmd_valid&cmd_ready, register the response and go to RESP.
  - RESP: cmd_ready=0, result_valid=1, result_* outputs held stable. When result_ready, go to IDLE.
  - Single-command occupancy. Minimum cmd-to-result latency is 1 cycle; throughput is 1 command per 2 cycles.
- Snapshot semantics: the CSR value returned is the counter value in the acceptance cycle, before that edge's increment. A retire asserted in the acceptance cycle is not visible in that read.
- Decode at acceptance:
  - funct3=0 (ENV):
    - funct12=0x000 and rs1=0: exception, cause 11.
    - funct12=0x001 and rs1=0: exception, cause 3.
    - Otherwise: cause 2.
  - funct3=4: cause 2.
  - funct3 in {1,5} (CSRRW/CSRRWI): cause 2 (counters are read-only).
  - funct3 in {2,3,6,7} with cmd_rs1!=0: cause 2 (write to read-only CSR).
  - funct3 in {2,3,6,7} with cmd_rs1=0: legal read, with this address map:
    - 0xC00 cycle[31:0]; 0xC80 cycle[63:32]
    - 0xC01 time[31:0]; 0xC81 time[63:32]
    - 0xC02 instret[31:0]; 0xC82 instret[63:32]
    - Any other address: cause 2.
- Result encoding:
  - On exception: result_data=0, result_exception=1.
  - On legal read: result_exception=0, result_cause=0.
  - result_rd = cmd_rd in all cases.
- Counters keep running in every state, including while a result is stalled.
- Reading low then high halves is not atomic; software handles rollover. No internal hi/lo latching.

Test Plan:
- Reset release, issue CSRRS rd=5 rs1=0 csr=0xC00 in the first idle cycle with result_ready=1 -> result_valid next cycle, rd=5, data=0, exception=0.
- Run 2^32+3 cycles with CYCLE_RESET=64'hFFFF_FFFF_FFFF_FFF0, then read 0xC00 and 0xC80 -> values consistent with wrap to 0 and continued counting; verify exact snapshot equals cycles elapsed.
- TIME_DIVIDER=4, idle 20 cycles, read 0xC01 -> 5; then hold result_ready=0 for 10 cycles -> result stable, cmd_ready=0, a new cmd_valid is not accepted.
- Pulse retire 7 times, with the 7th pulse in the same cycle as CSRRS 0xC02 acceptance -> data=6; a following read -> 7.
- ECALL (funct3=0, funct12=0) -> exception=1, cause=11, data=0; EBREAK -> cause 3; funct12=0x002 -> cause 2.
- CSRRW 0xC00, CSRRSI 0xC00 with zimm=1, CSRRS 0x300, funct3=4 -> each exception=1, cause=2; assert rst_n=0 during RESP -> result_valid drops immediately, counters return to reset values.
